mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, memory address width.
REQ-002 SHALL have parameter DWIDTH, default 32, memory data width.
REQ-003 SHALL have parameter CNTW, default 16, conflict counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_req_valid_i / i_req_ready_o  in/out  1/1  fetch request handshake.
REQ-007 i_addr_i  input  AWIDTH  fetch byte address.
REQ-008 i_rsp_valid_o / i_rsp_ready_i  out/in  1/1  fetch response handshake.
REQ-009 i_rsp_data_o  output  DWIDTH  fetched word.
REQ-010 d_req_valid_i / d_req_ready_o  in/out  1/1  load/store request handshake.
REQ-011 d_addr_i  input  AWIDTH; d_wdata_i  input  DWIDTH; d_we_i  input  1 (1 = store).
REQ-012 d_rsp_valid_o / d_rsp_ready_i  out/in  1/1; d_rsp_data_o  output  DWIDTH  load data, 0 for store ack.
REQ-013 mem_addr_o  output  AWIDTH; mem_data_o  output  DWIDTH; mem_read_en_o / mem_write_en_o  output  1/1.
REQ-014 mem_data_i  input  DWIDTH  combinational read data from the memory.
REQ-015 conflict_cnt_o  output  CNTW  count of cycles where both ports were eligible.

Function
REQ-016 Port eligible = req_valid_i high and its response slot free or draining this cycle (rsp_valid_o && rsp_ready_i).
REQ-017 At most one port granted per cycle; only granted port sees req_ready_o = 1, same cycle, combinationally.
REQ-018 Single eligible port SHALL be granted; no eligible port -> mem_read_en_o = mem_write_en_o = 0, mem_addr_o = 0.
REQ-019 Grant drives mem_addr_o from the winner's address; fetch grant: mem_read_en_o = 1; data grant: mem_write_en_o = d_we_i, mem_read_en_o = !d_we_i, mem_data_o = d_wdata_i.
REQ-020 Read grant captures mem_data_i into winner's response register at that edge; rsp_valid_o rises next cycle (latency 1).
REQ-021 Store grant: memory written at the same edge; d_rsp_valid_o rises next cycle with d_rsp_data_o = 0.
REQ-022 rsp_valid_o and rsp_data_o SHALL hold stable until rsp_ready_i is sampled high; drain and refill in same cycle allowed (back-to-back, one access per cycle).
REQ-023 Arbitration state: LAST_I / LAST_D register recording last winner, updated only on a granted cycle.
REQ-024 conflict_cnt_o increments on every cycle both ports are eligible; saturates at all-ones, never wraps.
REQ-025 Ungranted requester's inputs SHALL be ignored; request must be held by the requester until ready.

Reset
REQ-026 During rst: all req_ready_o = 0, mem_read_en_o = mem_write_en_o = 0, no memory write issued.
REQ-027 After rst: rsp_valid_o = 0, rsp_data_o = 0, last winner = LAST_D, conflict_cnt_o = 0.
REQ-028 Reset mid-operation drops any pending response without delivery.

Configuration
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN defined: on conflict, grant the port not recorded as last winner.
REQ-030 Macro undefined: on conflict, data port always wins (fixed priority); last-winner register still maintained.

Structure
REQ-031 mem_arb_pkg SHALL hold requester enum (REQ_I, REQ_D), last-winner typedef and read-data-for-store constant (0).
REQ-032 Response register per port SHALL be sub-module mem_arb_rsp_slot (valid/data hold, drain, refill), instantiated twice.

Verification
REQ-033 Fetch only, addr 0x01000000, memory word 0x00500093, rsp_ready=1 -> grant same cycle, i_rsp_valid next cycle, data 0x00500093.
REQ-034 Store 0xDEADBEEF to 0x01000010, then load same address -> store ack data 0, load returns 0xDEADBEEF.
REQ-035 Both valid 4 cycles, round-robin build -> grants alternate D,I,D,I; fixed build -> D,D,D,D with i_req_ready=0; conflict_cnt_o = 4.
REQ-036 i_rsp_ready held 0 after one fetch -> i_req_ready stays 0, i_rsp_data stable; data port still served each cycle.
REQ-037 rst asserted with d_rsp_valid pending and store request present -> no memory write, d_rsp_valid = 0 next cycle, counter 0.
REQ-038 Force 2^CNTW+3 conflict cycles -> conflict_cnt_o saturates at all-ones.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin conflict
// resolution. By default the data port has fixed priority.
package mem_arb_pkg;

  // Identifies which requester owns the memory in a given cycle.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_e;

  // Records the most recent winner; used as the round-robin pointer.
  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_t;

  // Value returned on the data response channel to acknowledge a store.
  localparam int STORE_RSP_DATA = 0;

endpackage

// File: rtl/mem_arb_rsp_slot.sv
// One-entry response register: captures read data on a granted access,
// holds valid/data until the consumer accepts, and allows drain and
// refill in the same cycle.
module mem_arb_rsp_slot #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DWIDTH-1:0] load_data,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              free
);

  // The slot can accept a new access when empty or emptying this cycle.
  assign free = !rsp_valid || rsp_ready;

  // Hold the response until accepted; a new load overrides the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-ported
// memory with combinational read data. One access per cycle.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin on conflict;
// otherwise the data port always wins a conflict.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. Requesters hold valid and payload until ready; ready
// here depends combinationally on valid. Response valid/data stay
// stable until the consumer's ready is sampled high.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid_i,
  output logic              i_req_ready_o,
  input  logic [AWIDTH-1:0] i_addr_i,
  output logic              i_rsp_valid_o,
  input  logic              i_rsp_ready_i,
  output logic [DWIDTH-1:0] i_rsp_data_o,
  input  logic              d_req_valid_i,
  output logic              d_req_ready_o,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic              d_we_i,
  output logic              d_rsp_valid_o,
  input  logic              d_rsp_ready_i,
  output logic [DWIDTH-1:0] d_rsp_data_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic [CNTW-1:0]   conflict_cnt_o,
  output last_t             last_winner_o
);

  logic  i_free, d_free;
  logic  i_elig, d_elig, conflict;
  logic  i_gnt, d_gnt;
  req_e  winner;
  last_t last_q;
  logic [DWIDTH-1:0] d_load_data;

  // Eligibility, winner selection and the memory-side command.
  always_comb begin
    i_elig   = !rst && i_req_valid_i && i_free;
    d_elig   = !rst && d_req_valid_i && d_free;
    conflict = i_elig && d_elig;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    winner = (last_q == LAST_D) ? REQ_I : REQ_D;
`else
    winner = REQ_D;
`endif
    if (!conflict) begin
      winner = i_elig ? REQ_I : REQ_D;
    end
    i_gnt          = i_elig && (winner == REQ_I);
    d_gnt          = d_elig && (winner == REQ_D);
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if (i_gnt) begin
      mem_addr_o    = i_addr_i;
      mem_read_en_o = 1'b1;
    end else if (d_gnt) begin
      mem_addr_o     = d_addr_i;
      mem_data_o     = d_wdata_i;
      mem_read_en_o  = !d_we_i;
      mem_write_en_o = d_we_i;
    end
  end

  assign i_req_ready_o  = i_gnt;
  assign d_req_ready_o  = d_gnt;
  assign d_load_data    = d_we_i ? DWIDTH'(STORE_RSP_DATA) : mem_data_i;
  assign last_winner_o  = last_q;

  // Last-winner state: only moves on a granted cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LAST_D;
    end else if (i_gnt) begin
      last_q <= LAST_I;
    end else if (d_gnt) begin
      last_q <= LAST_D;
    end
  end

  // Saturating count of cycles in which both ports were eligible.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_o <= '0;
    end else if (conflict && (conflict_cnt_o != {CNTW{1'b1}})) begin
      conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end

  mem_arb_rsp_slot #(.DWIDTH(DWIDTH)) u_i_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (i_gnt),
    .load_data (mem_data_i),
    .rsp_ready (i_rsp_ready_i),
    .rsp_valid (i_rsp_valid_o),
    .rsp_data  (i_rsp_data_o),
    .free      (i_free)
  );

  mem_arb_rsp_slot #(.DWIDTH(DWIDTH)) u_d_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (d_gnt),
    .load_data (d_load_data),
    .rsp_ready (d_rsp_ready_i),
    .rsp_valid (d_rsp_valid_o),
    .rsp_data  (d_rsp_data_o),
    .free      (d_free)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the port rules.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [31:0] BASE = 32'h0100_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_ready;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rsp_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic          mem_read_en, mem_write_en;
  logic [CW-1:0] conflict_cnt;
  last_t         last_winner;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .CNTW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid_i  (i_req_valid),
    .i_req_ready_o  (i_req_ready),
    .i_addr_i       (i_addr),
    .i_rsp_valid_o  (i_rsp_valid),
    .i_rsp_ready_i  (i_rsp_ready),
    .i_rsp_data_o   (i_rsp_data),
    .d_req_valid_i  (d_req_valid),
    .d_req_ready_o  (d_req_ready),
    .d_addr_i       (d_addr),
    .d_wdata_i      (d_wdata),
    .d_we_i         (d_we),
    .d_rsp_valid_o  (d_rsp_valid),
    .d_rsp_ready_i  (d_rsp_ready),
    .d_rsp_data_o   (d_rsp_data),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_data_o),
    .mem_read_en_o  (mem_read_en),
    .mem_write_en_o (mem_write_en),
    .mem_data_i     (mem_data_i),
    .conflict_cnt_o (conflict_cnt),
    .last_winner_o  (last_winner)
  );

  // 16-word memory at BASE, written only through the DUT's write port.
  logic [31:0] mem [16];
  assign mem_data_i = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_write_en) mem[mem_addr[5:2]] <= mem_data_o;

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [16];
  bit          m_i_valid, m_d_valid, m_last_d;
  logic [31:0] m_i_data, m_d_data;
  int          m_cnt;
  bit          last_gi, last_gd, obs_gi, obs_gd;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the combinational grant, advance the model, check
  // the registered outputs. Inputs are set by the caller before calling.
  task automatic tick();
    bit ie, de, gi, gd, cf;
    int ii, di;
    #1;
    ii = int'(i_addr[5:2]);
    di = int'(d_addr[5:2]);
    ie = !rst && i_req_valid && !(m_i_valid && !i_rsp_ready);
    de = !rst && d_req_valid && !(m_d_valid && !d_rsp_ready);
    cf = ie && de;
    gi = ie;
    gd = de;
    if (cf) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      gd = !m_last_d;
`else
      gd = 1'b1;
`endif
      gi = !gd;
    end
    obs_gi = i_req_ready;
    obs_gd = d_req_ready;
    chk("i_req_ready", i_req_ready, gi);
    chk("d_req_ready", d_req_ready, gd);
    chk("mem_read_en", mem_read_en, gi || (gd && !d_we));
    chk("mem_write_en", mem_write_en, gd && d_we);
    chk("mem_addr", mem_addr, gi ? i_addr : (gd ? d_addr : 32'h0));
    if (gd && d_we) chk("mem_data", mem_data_o, d_wdata);
    if (rst) begin
      m_i_valid = 0; m_d_valid = 0; m_i_data = 0; m_d_data = 0;
      m_last_d = 1; m_cnt = 0;
    end else begin
      if (m_i_valid && i_rsp_ready) m_i_valid = 0;
      if (m_d_valid && d_rsp_ready) m_d_valid = 0;
      if (gi) begin
        m_i_valid = 1; m_i_data = ref_mem[ii]; m_last_d = 0;
      end
      if (gd) begin
        m_d_valid = 1; m_d_data = d_we ? 32'h0 : ref_mem[di]; m_last_d = 1;
        if (d_we) ref_mem[di] = d_wdata;
      end
      if (cf && m_cnt < CMAX) m_cnt++;
    end
    last_gi = gi;
    last_gd = gd;
    @(posedge clk);
    #1;
    chk("i_rsp_valid", i_rsp_valid, m_i_valid);
    chk("d_rsp_valid", d_rsp_valid, m_d_valid);
    if (m_i_valid) chk("i_rsp_data", i_rsp_data, m_i_data);
    if (m_d_valid) chk("d_rsp_data", d_rsp_data, m_d_data);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("last_winner", last_winner, m_last_d);
    @(negedge clk);
  endtask

  // ---------------- driver helpers ----------------
  task automatic idle();
    i_req_valid = 0; i_addr = BASE; i_rsp_ready = 1;
    d_req_valid = 0; d_addr = BASE; d_wdata = 0; d_we = 0; d_rsp_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  logic [3:0]  pattern;
  logic [31:0] held, mem_before;

  initial begin
    // Reset, with a store presented during the second reset cycle.
    idle(); rst = 1;
    tick();
    d_req_valid = 1; d_we = 1; d_addr = BASE + 32'd36; d_wdata = 32'hFFFF_0000;
    tick();
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_i_valid", i_rsp_valid, 0);
    chk("rst_i_data", i_rsp_data, 0);
    chk("rst_d_data", d_rsp_data, 0);
    chk("rst_last", last_winner, LAST_D);
    rst = 0; idle();

    // Initialise every memory word through the data port.
    for (int k = 0; k < 16; k++) begin
      d_req_valid = 1; d_we = 1; d_addr = BASE + 32'(4 * k);
      d_wdata = (k == 0) ? 32'h0050_0093 : $urandom;
      tick();
    end
    idle();

    // Single fetch: granted same cycle, response one cycle later.
    i_req_valid = 1; i_addr = BASE;
    tick();
    chk("fetch_grant", obs_gi, 1);
    chk("fetch_rsp_valid", i_rsp_valid, 1);
    chk("fetch_rsp_data", i_rsp_data, 32'h0050_0093);
    idle(); tick();

    // Store then load of the same word.
    d_req_valid = 1; d_we = 1; d_addr = BASE + 32'h10; d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("store_ack_data", d_rsp_data, 0);
    d_we = 0;
    tick();
    chk("load_data", d_rsp_data, 32'hDEAD_BEEF);
    idle(); tick();

    // Four conflict cycles after a fetch left LAST_I recorded.
    do_reset(); idle();
    i_req_valid = 1; i_addr = BASE + 32'd4;
    tick();
    i_addr = BASE + 32'd8;
    d_req_valid = 1; d_addr = BASE + 32'd12;
    for (int c = 0; c < 4; c++) begin
      tick();
      pattern[c] = obs_gd;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("grant_pattern", pattern, 4'b0101);
`else
    chk("grant_pattern", pattern, 4'b1111);
`endif
    chk("conflict_4", conflict_cnt, 4);
    idle(); tick();

    // Fetch response stalled: fetch port blocked, data port still served.
    do_reset(); idle();
    held = ref_mem[5];
    i_req_valid = 1; i_addr = BASE + 32'd20; i_rsp_ready = 0;
    tick();
    i_addr = BASE + 32'd24;
    for (int c = 0; c < 4; c++) begin
      d_req_valid = 1; d_we = 0; d_addr = BASE + 32'(4 * $urandom_range(0, 15));
      tick();
      chk("stall_i_ready", obs_gi, 0);
      chk("stall_i_data", i_rsp_data, held);
      chk("stall_d_served", obs_gd, 1);
    end
    i_rsp_ready = 1; d_req_valid = 0;
    tick();
    chk("refill_grant", obs_gi, 1);
    idle(); tick();

    // Reset with a data response pending and a store on the port.
    i_req_valid = 1; i_addr = BASE;
    d_req_valid = 1; d_we = 1; d_addr = BASE + 32'd28; d_wdata = 32'h0BAD_F00D;
    d_rsp_ready = 0;
    tick();
    mem_before = ref_mem[7];
    rst = 1; d_wdata = 32'h1234_5678;
    tick();
    chk("rst_d_valid", d_rsp_valid, 0);
    chk("rst_cnt_clear", conflict_cnt, 0);
    chk("rst_no_write", mem[7], mem_before);
    rst = 0; idle(); tick();

    // Counter saturation: 2^CW + 3 conflict cycles.
    do_reset(); idle();
    i_req_valid = 1; d_req_valid = 1; d_we = 0;
    for (int c = 0; c < (1 << CW) + 3; c++) tick();
    chk("cnt_saturated", conflict_cnt, CMAX);
    idle(); tick();

    // Random traffic; requests are held until accepted.
    for (int c = 0; c < 300; c++) begin
      if (!i_req_valid || last_gi) begin
        i_req_valid = ($urandom_range(0, 3) != 0);
        i_addr = BASE + 32'(4 * $urandom_range(0, 15));
      end
      if (!d_req_valid || last_gd) begin
        d_req_valid = ($urandom_range(0, 3) != 0);
        d_we = ($urandom_range(0, 1) == 1);
        d_addr = BASE + 32'(4 * $urandom_range(0, 15));
        d_wdata = $urandom;
      end
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      d_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
